// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_VECTOR_DEF = 64'h0000_0000_8000_0000;
    localparam logic [ILEN-1:0] NOP_INST         = 32'h0000_0013;

    typedef enum logic [2:0] {
        IFU_REQ  = 3'd0,
        IFU_WAIT = 3'd1,
        IFU_OUT  = 3'd2,
        IFU_IDLE = 3'd3,
        IFU_DROP = 3'd4
    } ifu_state_t;

    function automatic logic is_misaligned(input logic [XLEN-1:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction-memory request/response bus plus the decode hand-off, seen from the fetch unit (master).
interface ifu_fetch_if;
    import ifu_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            imem_rsp_err;
    logic            inst_valid;
    logic            inst_ready;
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_fault;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_fault,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_fault,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err, inst_ready
    );

endinterface

// File: rtl/ifu_fetch_chk.sv
// Protocol checker for ifu_fetch: retire pulses only in IDLE, no request while one is outstanding.
module ifu_fetch_chk
    import ifu_pkg::*;
(
    input logic       clk,
    input logic       rst,
    input logic       i_pc_update,
    input logic       i_req_valid,
    input ifu_state_t i_state
);

    a_update_in_idle: assert property (@(posedge clk) disable iff (rst)
        i_pc_update |-> (i_state == IFU_IDLE))
        else $error("ifu_fetch_chk: pc_update_i asserted outside IDLE");

    a_single_outstanding: assert property (@(posedge clk) disable iff (rst)
        ((i_state == IFU_WAIT) || (i_state == IFU_DROP)) |-> !i_req_valid)
        else $error("ifu_fetch_chk: request raised while a response is outstanding");

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: architectural PC, single-outstanding imem read FSM, registered decode output.
// Optional macro IFU_MISALIGN_CHECK_EN: a misaligned PC faults locally with a NOP instead of reaching memory.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] pc_o,
    input  logic [XLEN-1:0] dnpc_i,
    input  logic            pc_update_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] flush_pc_i,
    ifu_fetch_if.master     bus
);

    ifu_state_t      r_state;
    ifu_state_t      w_next_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_inst_pc;
    logic [ILEN-1:0] r_inst;
    logic            r_inst_fault;
    logic            w_misalign;
    logic            w_req_valid;
    logic            w_inst_valid;
    logic            w_req_fire;
    logic            w_rsp_take;
    logic            w_local_fault;

`ifdef IFU_MISALIGN_CHECK_EN
    assign w_misalign = is_misaligned(r_pc);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_req_fire    = w_req_valid & bus.imem_req_ready;
    assign w_rsp_take    = (r_state == IFU_WAIT) & bus.imem_rsp_valid & ~flush_i;
    assign w_local_fault = (r_state == IFU_REQ) & w_misalign & ~flush_i;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IFU_REQ;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a flush redirects, but an accepted request still owes one response (DROP).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IFU_REQ: begin
                if (flush_i) begin
                    w_next_state = w_req_fire ? IFU_DROP : IFU_REQ;
                end else if (w_misalign) begin
                    w_next_state = IFU_OUT;
                end else if (w_req_fire) begin
                    w_next_state = IFU_WAIT;
                end else begin
                    w_next_state = IFU_REQ;
                end
            end
            IFU_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    w_next_state = flush_i ? IFU_REQ : IFU_OUT;
                end else begin
                    w_next_state = flush_i ? IFU_DROP : IFU_WAIT;
                end
            end
            IFU_OUT: begin
                if (flush_i) begin
                    w_next_state = IFU_REQ;
                end else if (bus.inst_ready) begin
                    w_next_state = IFU_IDLE;
                end else begin
                    w_next_state = IFU_OUT;
                end
            end
            IFU_IDLE: begin
                if (flush_i || pc_update_i) begin
                    w_next_state = IFU_REQ;
                end else begin
                    w_next_state = IFU_IDLE;
                end
            end
            IFU_DROP: begin
                if (bus.imem_rsp_valid) begin
                    w_next_state = IFU_REQ;
                end else begin
                    w_next_state = IFU_DROP;
                end
            end
            default: w_next_state = IFU_REQ;
        endcase
    end

    // FSM outputs, held inactive while reset is asserted.
    always_comb begin
        w_req_valid  = 1'b0;
        w_inst_valid = 1'b0;
        if (rst) begin
            w_req_valid  = 1'b0;
            w_inst_valid = 1'b0;
        end else begin
            case (r_state)
                IFU_REQ: w_req_valid  = ~w_misalign;
                IFU_OUT: w_inst_valid = 1'b1;
                default: begin
                    w_req_valid  = 1'b0;
                    w_inst_valid = 1'b0;
                end
            endcase
        end
    end

    // PC register: flush beats a retire, and a retire is only honoured in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_VECTOR;
        end else if (flush_i) begin
            r_pc <= flush_pc_i;
        end else if ((r_state == IFU_IDLE) && pc_update_i) begin
            r_pc <= dnpc_i;
        end else begin
            r_pc <= r_pc;
        end
    end

    // Decode output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst       <= {ILEN{1'b0}};
            r_inst_pc    <= {XLEN{1'b0}};
            r_inst_fault <= 1'b0;
        end else if (w_rsp_take) begin
            r_inst       <= bus.imem_rsp_data;
            r_inst_pc    <= r_pc;
            r_inst_fault <= bus.imem_rsp_err;
        end else if (w_local_fault) begin
            r_inst       <= NOP_INST;
            r_inst_pc    <= r_pc;
            r_inst_fault <= 1'b1;
        end else begin
            r_inst       <= r_inst;
            r_inst_pc    <= r_inst_pc;
            r_inst_fault <= r_inst_fault;
        end
    end

    assign pc_o               = r_pc;
    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.inst_valid     = w_inst_valid;
    assign bus.inst           = r_inst;
    assign bus.inst_pc        = r_inst_pc;
    assign bus.inst_fault     = r_inst_fault;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed plus randomized bench for ifu_fetch; reference model tracks the PC each fetch must deliver.
module tb_ifu_fetch;
    import ifu_pkg::*;

    localparam logic [63:0] RV = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc_o;
    logic [63:0] dnpc;
    logic        pc_update;
    logic        flush;
    logic [63:0] flush_pc;

    int tests = 0;
    int fails = 0;

    logic [63:0] model_pc;
    logic [63:0] target;
    logic [63:0] npc;
    int          lat;
    int          hold;
    bit          fired;

    always #5 clk = ~clk;

    ifu_fetch_if bus ();

    ifu_fetch #(.RESET_VECTOR(RV)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_o       (pc_o),
        .dnpc_i     (dnpc),
        .pc_update_i(pc_update),
        .flush_i    (flush),
        .flush_pc_i (flush_pc),
        .bus        (bus)
    );

    ifu_fetch_chk u_chk (
        .clk        (clk),
        .rst        (rst),
        .i_pc_update(pc_update),
        .i_req_valid(bus.imem_req_valid),
        .i_state    (dut.r_state)
    );

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic mem_err(input logic [63:0] a);
        return (a[4:2] == 3'b111);
    endfunction

    function automatic logic [63:0] rand_pc();
        logic [31:0] r;
        r = $urandom;
        return {32'h0000_0000, 32'h8000_0000 | (r & 32'h000F_FFFC)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept the pending request, answer it lat cycles after acceptance.
    task automatic serve(input int l, input logic [31:0] data, input logic err);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        repeat (l - 1) tick();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = data;
        bus.imem_rsp_err   = err;
        tick();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_err   = 1'b0;
    endtask

    task automatic take();
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
    endtask

    task automatic retire(input logic [63:0] n);
        pc_update = 1'b1;
        dnpc      = n;
        tick();
        pc_update = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; pc_update = 1'b0; flush = 1'b0; dnpc = 64'h0; flush_pc = 64'h0;
        bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = 32'h0; bus.imem_rsp_err = 1'b0; bus.inst_ready = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_req_valid", {63'h0, bus.imem_req_valid}, 64'h0);
        chk("rst_inst_valid", {63'h0, bus.inst_valid}, 64'h0);
        chk("rst_pc", pc_o, RV);
        chk("rst_inst", {32'h0, bus.inst}, 64'h0);
        chk("rst_inst_pc", bus.inst_pc, 64'h0);
        chk("rst_fault", {63'h0, bus.inst_fault}, 64'h0);
        rst = 1'b0;
        #1;
        chk("first_req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
        chk("first_req_addr", bus.imem_req_addr, RV);

        // Basic fetch, response two cycles after acceptance
        serve(2, 32'h0000_0297, 1'b0);
        chk("t1_valid", {63'h0, bus.inst_valid}, 64'h1);
        chk("t1_inst", {32'h0, bus.inst}, 64'h0000_0297);
        chk("t1_inst_pc", bus.inst_pc, RV);
        chk("t1_fault", {63'h0, bus.inst_fault}, 64'h0);

        // Decode stalls five cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", {63'h0, bus.inst_valid}, 64'h1);
            chk("hold_inst", {32'h0, bus.inst}, 64'h0000_0297);
            chk("hold_inst_pc", bus.inst_pc, RV);
            chk("hold_no_req", {63'h0, bus.imem_req_valid}, 64'h0);
        end
        take();
        chk("idle_inst_valid", {63'h0, bus.inst_valid}, 64'h0);
        chk("idle_no_req", {63'h0, bus.imem_req_valid}, 64'h0);
        retire(64'h0000_0000_8000_0004);
        chk("upd_req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
        chk("upd_req_addr", bus.imem_req_addr, 64'h0000_0000_8000_0004);

        // Flush while waiting for the response
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        flush = 1'b1; flush_pc = 64'h0000_0000_8000_1000;
        tick();
        flush = 1'b0;
        chk("fw_pc", pc_o, 64'h0000_0000_8000_1000);
        chk("fw_no_req", {63'h0, bus.imem_req_valid}, 64'h0);
        tick();
        bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hDEAD_BEEF;
        tick();
        bus.imem_rsp_valid = 1'b0;
        chk("fw_stale_dropped", {63'h0, bus.inst_valid}, 64'h0);
        chk("fw_req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
        chk("fw_req_addr", bus.imem_req_addr, 64'h0000_0000_8000_1000);
        serve(1, 32'h0010_0093, 1'b0);
        chk("fw_inst", {32'h0, bus.inst}, 64'h0010_0093);
        chk("fw_inst_pc", bus.inst_pc, 64'h0000_0000_8000_1000);
        take();
        retire(64'h0000_0000_8000_1004);

        // Flush on the same cycle the request is accepted
        bus.imem_req_ready = 1'b1; flush = 1'b1; flush_pc = 64'h0000_0000_8000_2000;
        tick();
        bus.imem_req_ready = 1'b0; flush = 1'b0;
        chk("fr_pc", pc_o, 64'h0000_0000_8000_2000);
        chk("fr_no_req0", {63'h0, bus.imem_req_valid}, 64'h0);
        tick();
        chk("fr_no_req1", {63'h0, bus.imem_req_valid}, 64'h0);
        bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hCAFE_F00D;
        tick();
        bus.imem_rsp_valid = 1'b0;
        chk("fr_inst_valid", {63'h0, bus.inst_valid}, 64'h0);
        chk("fr_req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
        chk("fr_req_addr", bus.imem_req_addr, 64'h0000_0000_8000_2000);
        serve(3, 32'h1111_1111, 1'b0);
        chk("fr_inst", {32'h0, bus.inst}, 64'h1111_1111);
        chk("fr_inst_pc", bus.inst_pc, 64'h0000_0000_8000_2000);
        take();
        retire(64'h0000_0000_8000_2004);

        // Access fault
        serve(1, 32'h0000_0000, 1'b1);
        chk("err_valid", {63'h0, bus.inst_valid}, 64'h1);
        chk("err_fault", {63'h0, bus.inst_fault}, 64'h1);
        chk("err_inst_pc", bus.inst_pc, 64'h0000_0000_8000_2004);
        take();
        retire(64'h0000_0000_8000_3000);

        // Reset while waiting; the stray response must be ignored
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        chk("rw_pc", pc_o, RV);
        chk("rw_inst_valid", {63'h0, bus.inst_valid}, 64'h0);
        chk("rw_inst", {32'h0, bus.inst}, 64'h0);
        rst = 1'b0;
        bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hBAD0_BAD0;
        tick();
        bus.imem_rsp_valid = 1'b0;
        chk("rw_stray_inst_valid", {63'h0, bus.inst_valid}, 64'h0);
        chk("rw_req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
        chk("rw_req_addr", bus.imem_req_addr, RV);
        serve(2, 32'h0000_0297, 1'b0);
        chk("rw_inst", {32'h0, bus.inst}, 64'h0000_0297);
        take();

        // Misaligned next PC
        retire(64'h0000_0000_8000_0002);
`ifdef IFU_MISALIGN_CHECK_EN
        chk("mis_no_req", {63'h0, bus.imem_req_valid}, 64'h0);
        tick();
        chk("mis_valid", {63'h0, bus.inst_valid}, 64'h1);
        chk("mis_inst", {32'h0, bus.inst}, 64'h0000_0013);
        chk("mis_fault", {63'h0, bus.inst_fault}, 64'h1);
        chk("mis_inst_pc", bus.inst_pc, 64'h0000_0000_8000_0002);
`else
        chk("mis_req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
        chk("mis_req_addr", bus.imem_req_addr, 64'h0000_0000_8000_0002);
        serve(1, 32'h0000_0001, 1'b0);
        chk("mis_fault", {63'h0, bus.inst_fault}, 64'h0);
        chk("mis_inst_pc", bus.inst_pc, 64'h0000_0000_8000_0002);
`endif
        take();
        model_pc = 64'h0000_0000_8000_0100;
        retire(model_pc);

        // Randomized traffic: every fetch of model_pc must deliver mem_word(model_pc)
        for (int n = 0; n < 150; n++) begin
            fired = 1'b0;
            for (int c = 0; c < 40 && !fired; c++) begin
                if (bus.imem_req_valid) begin
                    bus.imem_req_ready = ($urandom_range(0, 2) != 0);
                    if (bus.imem_req_ready) begin
                        chk("rnd_req_addr", bus.imem_req_addr, model_pc);
                        fired = 1'b1;
                    end
                end else begin
                    bus.imem_req_ready = 1'b0;
                end
                tick();
            end
            bus.imem_req_ready = 1'b0;
            chk("rnd_req_issued", {63'h0, fired}, 64'h1);
            lat = $urandom_range(1, 4);
            if ($urandom_range(0, 5) == 0) begin
                target = rand_pc();
                flush = 1'b1; flush_pc = target;
                tick();
                flush = 1'b0;
                model_pc = target;
                repeat (lat - 1) tick();
                chk("rnd_drop_no_req", {63'h0, bus.imem_req_valid}, 64'h0);
                bus.imem_rsp_valid = 1'b1; bus.imem_rsp_data = 32'hDEAD_BEEF;
                tick();
                bus.imem_rsp_valid = 1'b0;
                chk("rnd_drop_no_inst", {63'h0, bus.inst_valid}, 64'h0);
                continue;
            end
            repeat (lat - 1) begin
                chk("rnd_wait_no_req", {63'h0, bus.imem_req_valid}, 64'h0);
                tick();
            end
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(model_pc);
            bus.imem_rsp_err   = mem_err(model_pc);
            tick();
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_err   = 1'b0;
            hold = $urandom_range(0, 3);
            repeat (hold) tick();
            chk("rnd_inst_valid", {63'h0, bus.inst_valid}, 64'h1);
            chk("rnd_inst", {32'h0, bus.inst}, {32'h0, mem_word(model_pc)});
            chk("rnd_inst_pc", bus.inst_pc, model_pc);
            chk("rnd_fault", {63'h0, bus.inst_fault}, {63'h0, mem_err(model_pc)});
            if ($urandom_range(0, 7) == 0) begin
                target = rand_pc();
                flush = 1'b1; flush_pc = target;
                tick();
                flush = 1'b0;
                model_pc = target;
                chk("rnd_out_flush_valid", {63'h0, bus.inst_valid}, 64'h0);
                continue;
            end
            take();
            chk("rnd_idle_valid", {63'h0, bus.inst_valid}, 64'h0);
            repeat ($urandom_range(0, 2)) tick();
            npc = ($urandom_range(0, 3) == 0) ? rand_pc() : model_pc + 64'd4;
            if ($urandom_range(0, 9) == 0) begin
                target = rand_pc();
                flush = 1'b1; flush_pc = target;
                model_pc = target;
            end else begin
                model_pc = npc;
            end
            retire(npc);
            flush = 1'b0;
            chk("rnd_pc", pc_o, model_pc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
